// File: rtl/eq_pkg.sv
// Shared types, coefficient layout and fixed-point helpers for the multiband equaliser.
package eq_pkg;

  typedef enum logic [2:0] {StIdle, StMac, StWb, StGain, StOut} eq_state_e;

  localparam int CoefB0         = 0;
  localparam int CoefB1         = 1;
  localparam int CoefB2         = 2;
  localparam int CoefA1         = 3;
  localparam int CoefA2         = 4;
  localparam int CoefGain       = 5;
  localparam int NumCoefPerBand = 6;

  // Identity response: unity b0 and unity gain on band 0 only.
  localparam int IdentityBand   = 0;

  function automatic int identity_coef(input int idx, input int frac);
    int band;
    int sel;
    band = idx / NumCoefPerBand;
    sel  = idx % NumCoefPerBand;
    if (band == IdentityBand && (sel == CoefB0 || sel == CoefGain)) return 1 << frac;
    return 0;
  endfunction

  // Round half up at bit frac, then clamp to a signed width-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int width, input int frac);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/eq_mac.sv
// Shared signed multiplier with add/subtract accumulator and round/saturate readout.
module eq_mac
  import eq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 14,
  parameter int unsigned ACC_W = 2 * WIDTH + 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic                    acc_en_i,
  input  logic                    sub_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [ACC_W-1:0] prod_o,
  output logic signed [WIDTH-1:0] rnd_o
);

  logic signed [2*WIDTH-1:0] mul;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  assign mul    = a_i * b_i;
  assign prod_o = ACC_W'(mul);
  assign rnd_o  = WIDTH'(round_sat(64'(acc_q), int'(WIDTH), int'(FRAC)));

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = sub_i ? acc_q - prod_o : acc_q + prod_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) acc_q <= '0;
    else         acc_q <= acc_d;
  end

endmodule

// File: rtl/multiband_eq.sv
// N-band, multi-channel biquad equaliser sharing one multiplier under a sequencing FSM.
module multiband_eq
  import eq_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FRAC   = 14,
  parameter int unsigned NBANDS = 3,
  parameter int unsigned NCH    = 2,
  parameter int unsigned ACC_W  = 2 * WIDTH + 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(NCH)-1:0]        in_ch,
  input  logic signed [WIDTH-1:0]       audio_in,
  output logic                          out_valid,
  output logic [$clog2(NCH)-1:0]        out_ch,
  output logic signed [WIDTH-1:0]       audio_out,
  input  logic                          bypass,
  input  logic                          coef_we,
  output logic                          coef_ready,
  input  logic [$clog2(6*NBANDS)-1:0]   coef_addr,
  input  logic signed [WIDTH-1:0]       coef_wdata
);

  localparam int unsigned NCOEF = 6 * NBANDS;
  localparam int unsigned CA_W  = $clog2(NCOEF);
  localparam int unsigned CH_W  = $clog2(NCH);
  localparam int unsigned BW    = $clog2(NBANDS);

  typedef logic signed [WIDTH-1:0] samp_t;

  eq_state_e               state_q, state_d;
  logic [2:0]              tap_q, tap_d;
  logic [BW-1:0]           band_q, band_d;
  samp_t                   x_q, x_d, yk_q, yk_d, res_q, res_d, audio_out_q, audio_out_d;
  logic [CH_W-1:0]         ch_q, ch_d, out_ch_q, out_ch_d;
  logic                    byp_q, byp_d, out_phase_q, out_phase_d, out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  samp_t                   coef_q [NCOEF], coef_d [NCOEF];
  samp_t                   x1_q [NCH], x1_d [NCH], x2_q [NCH], x2_d [NCH];
  samp_t                   y1_q [NCH][NBANDS], y1_d [NCH][NBANDS];
  samp_t                   y2_q [NCH][NBANDS], y2_d [NCH][NBANDS];

  logic                    mac_clr, mac_acc_en, mac_sub;
  samp_t                   mac_a, mac_b, mac_rnd;
  logic signed [ACC_W-1:0] mac_prod;
  logic [CA_W-1:0]         coef_idx;

  assign in_ready   = (state_q == StIdle);
  assign coef_ready = in_ready;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign audio_out  = audio_out_q;

  assign coef_idx = CA_W'(32'(band_q) * 6 +
                          ((state_q == StGain) ? 32'(CoefGain) : 32'(tap_q)));

  eq_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (mac_clr),
    .acc_en_i (mac_acc_en),
    .sub_i    (mac_sub),
    .a_i      (mac_a),
    .b_i      (mac_b),
    .prod_o   (mac_prod),
    .rnd_o    (mac_rnd)
  );

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    band_d      = band_q;
    x_d         = x_q;
    ch_d        = ch_q;
    byp_d       = byp_q;
    yk_d        = yk_q;
    res_d       = res_q;
    out_acc_d   = out_acc_q;
    out_phase_d = out_phase_q;
    audio_out_d = audio_out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    mac_clr     = 1'b0;
    mac_acc_en  = 1'b0;
    mac_sub     = 1'b0;
    mac_a       = coef_q[coef_idx];
    mac_b       = x_q;

    if (state_q == StIdle && coef_we && 32'(coef_addr) < NCOEF) begin
      coef_d[coef_addr] = coef_wdata;
    end

    unique case (state_q)
      StIdle: begin
        // Out-of-range channels are consumed without touching any state.
        if (in_valid && 32'(in_ch) < NCH) begin
          x_d         = audio_in;
          ch_d        = in_ch;
          byp_d       = bypass;
          band_d      = '0;
          tap_d       = '0;
          out_acc_d   = '0;
          out_phase_d = 1'b0;
          mac_clr     = 1'b1;
          state_d     = StMac;
        end
      end
      StMac: begin
        mac_acc_en = 1'b1;
        case (tap_q)
          3'd0:    mac_b = x_q;
          3'd1:    mac_b = x1_q[ch_q];
          3'd2:    mac_b = x2_q[ch_q];
          3'd3:    begin mac_b = y1_q[ch_q][band_q]; mac_sub = 1'b1; end
          default: begin mac_b = y2_q[ch_q][band_q]; mac_sub = 1'b1; end
        endcase
        if (tap_q == 3'd4) state_d = StWb;
        else               tap_d   = tap_q + 3'd1;
      end
      StWb: begin
        yk_d                 = mac_rnd;
        y2_d[ch_q][band_q]   = y1_q[ch_q][band_q];
        y1_d[ch_q][band_q]   = mac_rnd;
        state_d              = StGain;
      end
      StGain: begin
        mac_b     = yk_q;
        mac_clr   = 1'b1;
        out_acc_d = out_acc_q + mac_prod;
        if (32'(band_q) == NBANDS - 1) begin
          state_d = StOut;
        end else begin
          band_d  = band_q + BW'(1);
          tap_d   = '0;
          state_d = StMac;
        end
      end
      StOut: begin
        // Two phases: register the rounded sum first, then publish.
        if (!out_phase_q) begin
          res_d       = WIDTH'(round_sat(64'(out_acc_q), int'(WIDTH), int'(FRAC)));
          out_phase_d = 1'b1;
        end else begin
          audio_out_d = byp_q ? x_q : res_q;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          x2_d[ch_q]  = x1_q[ch_q];
          x1_d[ch_q]  = x_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      band_q      <= '0;
      x_q         <= '0;
      ch_q        <= '0;
      byp_q       <= 1'b0;
      yk_q        <= '0;
      res_q       <= '0;
      out_acc_q   <= '0;
      out_phase_q <= 1'b0;
      audio_out_q <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NCOEF; i++) begin
        coef_q[i] <= WIDTH'(identity_coef(int'(i), int'(FRAC)));
      end
      for (int unsigned c = 0; c < NCH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        for (int unsigned k = 0; k < NBANDS; k++) begin
          y1_q[c][k] <= '0;
          y2_q[c][k] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      band_q      <= band_d;
      x_q         <= x_d;
      ch_q        <= ch_d;
      byp_q       <= byp_d;
      yk_q        <= yk_d;
      res_q       <= res_d;
      out_acc_q   <= out_acc_d;
      out_phase_q <= out_phase_d;
      audio_out_q <= audio_out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

endmodule

// File: tb/tb_multiband_eq.sv
// Randomised bench for multiband_eq against a per-sample arithmetic reference model.
module tb_multiband_eq;

  localparam int W      = 16;
  localparam int FRAC   = 14;
  localparam int NBANDS = 3;
  localparam int NCH    = 3;
  localparam int NCOEF  = 6 * NBANDS;
  localparam int CH_W   = $clog2(NCH);
  localparam int CA_W   = $clog2(NCOEF);
  localparam int LAT    = 7 * NBANDS + 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CH_W-1:0]      in_ch = '0;
  logic signed [W-1:0]  audio_in = '0;
  logic                 out_valid;
  logic [CH_W-1:0]      out_ch;
  logic signed [W-1:0]  audio_out;
  logic                 bypass = 1'b0;
  logic                 coef_we = 1'b0;
  logic                 coef_ready;
  logic [CA_W-1:0]      coef_addr = '0;
  logic signed [W-1:0]  coef_wdata = '0;

  int n_vec = 0;
  int n_err = 0;

  longint m_coef [NCOEF];
  longint m_x1 [NCH], m_x2 [NCH];
  longint m_y1 [NCH][NBANDS], m_y2 [NCH][NBANDS];

  multiband_eq #(
    .WIDTH  (W),
    .FRAC   (FRAC),
    .NBANDS (NBANDS),
    .NCH    (NCH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .audio_in   (audio_in),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .audio_out  (audio_out),
    .bypass     (bypass),
    .coef_we    (coef_we),
    .coef_ready (coef_ready),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic longint sx(input int v);
    logic signed [W-1:0] t;
    t = W'(v);
    return longint'(t);
  endfunction

  function automatic longint rsat(input longint a);
    longint r;
    r = (a + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (r > (longint'(1) << (W - 1)) - 1) r = (longint'(1) << (W - 1)) - 1;
    if (r < -(longint'(1) << (W - 1))) r = -(longint'(1) << (W - 1));
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCOEF; i++) m_coef[i] = (i == 0 || i == 5) ? (longint'(1) << FRAC) : 0;
    for (int c = 0; c < NCH; c++) begin
      m_x1[c] = 0;
      m_x2[c] = 0;
      for (int k = 0; k < NBANDS; k++) begin
        m_y1[c][k] = 0;
        m_y2[c][k] = 0;
      end
    end
  endfunction

  // One sample through every band: direct-form biquads, gain-weighted sum.
  function automatic longint model_step(input int c, input longint x, input bit byp);
    longint sum, acc, y;
    sum = 0;
    for (int k = 0; k < NBANDS; k++) begin
      acc = m_coef[6*k] * x + m_coef[6*k+1] * m_x1[c] + m_coef[6*k+2] * m_x2[c]
          - m_coef[6*k+3] * m_y1[c][k] - m_coef[6*k+4] * m_y2[c][k];
      y = rsat(acc);
      m_y2[c][k] = m_y1[c][k];
      m_y1[c][k] = y;
      sum += m_coef[6*k+5] * y;
    end
    m_x2[c] = m_x1[c];
    m_x1[c] = x;
    return byp ? x : rsat(sum);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int addr, input int val);
    check_eq("coef_ready_idle", coef_ready, 1);
    coef_we = 1'b1;
    coef_addr = CA_W'(addr);
    coef_wdata = W'(val);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    m_coef[addr] = sx(val);
  endtask

  // Accept one sample (optionally with a same-cycle coefficient write), then time the result.
  task automatic run_sample(input int ch, input int x, input bit byp, input bit wr,
                            input int waddr, input int wdata, input bit poke);
    int lat;
    longint exp;
    check_eq("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_ch = CH_W'(ch);
    audio_in = W'(x);
    bypass = byp;
    coef_we = wr;
    coef_addr = CA_W'(waddr);
    coef_wdata = W'(wdata);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    if (wr) m_coef[waddr] = sx(wdata);
    lat = 0;
    for (int c = 1; c <= LAT + 15 && lat == 0; c++) begin
      if (poke && c == 5) begin
        check_eq("busy_in_ready", in_ready, 0);
        check_eq("busy_coef_ready", coef_ready, 0);
        in_valid = 1'b1;
        in_ch = '0;
        audio_in = W'($urandom);
        coef_we = 1'b1;
        coef_addr = '0;
        coef_wdata = '0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      coef_we = 1'b0;
      if (out_valid) lat = c;
    end
    if (ch >= NCH) begin
      check_eq("discard_no_output", lat, 0);
    end else begin
      exp = model_step(ch, sx(x), byp);
      check_eq("latency", lat, LAT);
      check_eq("audio_out", audio_out, exp);
      check_eq("out_ch", out_ch, ch);
      check_eq("in_ready_with_valid", in_ready, 1);
    end
  endtask

  initial begin
    int seen;
    model_reset();
    do_reset();

    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_coef_ready", coef_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_audio_out", audio_out, 0);
    check_eq("rst_out_ch", out_ch, 0);

    // Identity path
    run_sample(0, 'h2000, 0, 0, 0, 0, 0);
    check_eq("identity_2000", audio_out, 'h2000);
    run_sample(0, 'h7FFF, 0, 0, 0, 0, 0);
    check_eq("identity_7fff", audio_out, 'h7FFF);

    // Saturation
    write_coef(0, 'h7FFF);
    run_sample(0, 'h7FFF, 0, 0, 0, 0, 0);
    check_eq("sat_pos", audio_out, 'h7FFF);
    run_sample(0, 'h8000, 0, 0, 0, 0, 0);
    check_eq("sat_neg", audio_out, -32768);

    // Delay line and channel isolation
    do_reset();
    write_coef(0, 0);
    write_coef(1, 'h4000);
    run_sample(0, 'h4000, 0, 0, 0, 0, 0);
    check_eq("delay_0", audio_out, 0);
    run_sample(1, 'h1000, 0, 0, 0, 0, 0);
    check_eq("delay_1", audio_out, 0);
    run_sample(0, 0, 0, 0, 0, 0, 0);
    check_eq("delay_2", audio_out, 'h4000);
    run_sample(1, 0, 0, 0, 0, 0, 0);
    check_eq("delay_3", audio_out, 'h1000);

    // Feedback recursion
    do_reset();
    write_coef(3, 'hE000);
    run_sample(0, 'h2000, 0, 0, 0, 0, 0);
    check_eq("recur_0", audio_out, 'h2000);
    run_sample(0, 'h2000, 0, 0, 0, 0, 0);
    check_eq("recur_1", audio_out, 'h3000);
    run_sample(0, 'h2000, 0, 0, 0, 0, 0);
    check_eq("recur_2", audio_out, 'h3800);

    // Band sum, busy-ignore, bypass, out-of-range channel
    do_reset();
    write_coef(5, 'h2000);
    write_coef(6, 'h4000);
    write_coef(11, 'h2000);
    run_sample(1, 'h4000, 0, 0, 0, 0, 1);
    check_eq("band_sum", audio_out, 'h4000);
    run_sample(1, 'h4000, 0, 0, 0, 0, 0);
    run_sample(3, 'h1234, 0, 0, 0, 0, 0);
    run_sample(1, 'h2000, 0, 0, 0, 0, 0);
    write_coef(5, 0);
    run_sample(0, 'h5A5A, 1, 0, 0, 0, 0);
    check_eq("bypass", audio_out, 'h5A5A);
    run_sample(0, 'h1000, 0, 0, 0, 0, 0);

    // Randomised traffic with random coefficients and same-cycle writes
    do_reset();
    for (int i = 0; i < 45; i++) begin
      int ch;
      bit wr;
      if ($urandom_range(0, 3) == 0) write_coef($urandom_range(0, NCOEF - 1), $urandom_range(0, 'h6000) - 'h3000);
      ch = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NCH - 1);
      wr = ($urandom_range(0, 3) == 0);
      run_sample(ch, $urandom, $urandom_range(0, 7) == 0, wr, $urandom_range(0, NCOEF - 1),
                 $urandom_range(0, 'h6000) - 'h3000, 0);
    end

    // Reset in the middle of a sample
    check_eq("pre_abort_ready", in_ready, 1);
    in_valid = 1'b1;
    in_ch = '0;
    audio_in = W'('h1234);
    bypass = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_eq("abort_no_output", seen, 0);
    run_sample(2, 'h2468, 0, 0, 0, 0, 0);
    check_eq("abort_identity", audio_out, 'h2468);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
